// File: rtl/e203_exu_oitf_sched.sv
// Outstanding-instruction tracking FIFO for long-pipe ops.
// Allocates ITAGs at dispatch and retires in order at writeback.
module e203_exu_oitf_sched #(
    parameter int DEPTH   = 2,
    parameter int PTR_W   = 1,
    parameter int RFIDX_W = 5,
    parameter int PC_W    = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               dis_ena,
    output logic               dis_ready,
    output logic [PTR_W-1:0]   dis_ptr,
    input  logic               dis_rs1en,
    input  logic               dis_rs2en,
    input  logic               dis_rs3en,
    input  logic               dis_rs1fpu,
    input  logic               dis_rs2fpu,
    input  logic               dis_rs3fpu,
    input  logic [RFIDX_W-1:0] dis_rs1idx,
    input  logic [RFIDX_W-1:0] dis_rs2idx,
    input  logic [RFIDX_W-1:0] dis_rs3idx,
    input  logic               dis_rdwen,
    input  logic               dis_rdfpu,
    input  logic [RFIDX_W-1:0] dis_rdidx,
    input  logic [PC_W-1:0]    dis_pc,
    input  logic               ret_ena,
    output logic [PTR_W-1:0]   ret_ptr,
    output logic               ret_rdwen,
    output logic               ret_rdfpu,
    output logic [RFIDX_W-1:0] ret_rdidx,
    output logic [PC_W-1:0]    ret_pc,
    output logic               match_rs1,
    output logic               match_rs2,
    output logic               match_rs3,
    output logic               match_rd,
    output logic               empty,
    output logic               full,
    output logic               err_underflow
);

    localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

    logic [PTR_W-1:0]   r_alc_ptr;
    logic               r_alc_wrap;
    logic [PTR_W-1:0]   r_ret_ptr;
    logic               r_ret_wrap;
    logic               r_err;
    logic [DEPTH-1:0]   r_vld;
    logic               r_rdwen [DEPTH];
    logic               r_rdfpu [DEPTH];
    logic [RFIDX_W-1:0] r_rdidx [DEPTH];
    logic [PC_W-1:0]    r_pc    [DEPTH];

    logic w_ptr_eq;
    logic w_alc;
    logic w_ret;

    assign w_ptr_eq = (r_alc_ptr == r_ret_ptr);
    assign empty    = w_ptr_eq & (r_alc_wrap == r_ret_wrap);
    assign full     = w_ptr_eq & (r_alc_wrap != r_ret_wrap);
    assign dis_ready = ~full;
    assign w_alc    = dis_ena & ~full;
    assign w_ret    = ret_ena & ~empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_alc_ptr  <= '0;
            r_alc_wrap <= 1'b0;
            r_ret_ptr  <= '0;
            r_ret_wrap <= 1'b0;
            r_vld      <= '0;
            r_err      <= 1'b0;
        end else begin
            if (w_alc) begin
                r_vld[r_alc_ptr] <= 1'b1;
                r_alc_ptr        <= r_alc_ptr + 1'b1;
                if (r_alc_ptr == LAST)
                    r_alc_wrap <= ~r_alc_wrap;
            end
            // Full blocks alloc and empty blocks retire, so slots never collide
            if (w_ret) begin
                r_vld[r_ret_ptr] <= 1'b0;
                r_ret_ptr        <= r_ret_ptr + 1'b1;
                if (r_ret_ptr == LAST)
                    r_ret_wrap <= ~r_ret_wrap;
            end
            if (ret_ena & empty)
                r_err <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_alc) begin
            r_rdwen[r_alc_ptr] <= dis_rdwen;
            r_rdfpu[r_alc_ptr] <= dis_rdfpu;
            r_rdidx[r_alc_ptr] <= dis_rdidx;
            r_pc[r_alc_ptr]    <= dis_pc;
        end
    end

    assign err_underflow = r_err;
    assign dis_ptr       = r_alc_ptr;
    assign ret_ptr       = r_ret_ptr;
    assign ret_rdwen     = r_rdwen[r_ret_ptr];
    assign ret_rdfpu     = r_rdfpu[r_ret_ptr];
    assign ret_rdidx     = r_rdidx[r_ret_ptr];
    assign ret_pc        = r_pc[r_ret_ptr];

    always_comb begin
        logic w_hit;
        match_rs1 = 1'b0;
        match_rs2 = 1'b0;
        match_rs3 = 1'b0;
        match_rd  = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            w_hit = r_vld[i] & r_rdwen[i];
            match_rs1 |= w_hit & dis_rs1en
                       & (r_rdfpu[i] == dis_rs1fpu)
                       & (r_rdidx[i] == dis_rs1idx);
            match_rs2 |= w_hit & dis_rs2en
                       & (r_rdfpu[i] == dis_rs2fpu)
                       & (r_rdidx[i] == dis_rs2idx);
            match_rs3 |= w_hit & dis_rs3en
                       & (r_rdfpu[i] == dis_rs3fpu)
                       & (r_rdidx[i] == dis_rs3idx);
            match_rd  |= w_hit & dis_rdwen
                       & (r_rdfpu[i] == dis_rdfpu)
                       & (r_rdidx[i] == dis_rdidx);
        end
    end

endmodule

// File: tb/tb_e203_exu_oitf_sched.sv
// Directed bench for e203_exu_oitf_sched with DEPTH=2.
module tb_e203_exu_oitf_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic        dis_ena;
    logic        dis_ready;
    logic [0:0]  dis_ptr;
    logic        dis_rs1en, dis_rs2en, dis_rs3en;
    logic        dis_rs1fpu, dis_rs2fpu, dis_rs3fpu;
    logic [4:0]  dis_rs1idx, dis_rs2idx, dis_rs3idx;
    logic        dis_rdwen, dis_rdfpu;
    logic [4:0]  dis_rdidx;
    logic [31:0] dis_pc;
    logic        ret_ena;
    logic [0:0]  ret_ptr;
    logic        ret_rdwen, ret_rdfpu;
    logic [4:0]  ret_rdidx;
    logic [31:0] ret_pc;
    logic        match_rs1, match_rs2, match_rs3, match_rd;
    logic        empty, full, err_underflow;

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    e203_exu_oitf_sched #(
        .DEPTH(2), .PTR_W(1), .RFIDX_W(5), .PC_W(32)
    ) dut (
        .clk(clk), .rst(rst),
        .dis_ena(dis_ena), .dis_ready(dis_ready), .dis_ptr(dis_ptr),
        .dis_rs1en(dis_rs1en), .dis_rs2en(dis_rs2en), .dis_rs3en(dis_rs3en),
        .dis_rs1fpu(dis_rs1fpu), .dis_rs2fpu(dis_rs2fpu), .dis_rs3fpu(dis_rs3fpu),
        .dis_rs1idx(dis_rs1idx), .dis_rs2idx(dis_rs2idx), .dis_rs3idx(dis_rs3idx),
        .dis_rdwen(dis_rdwen), .dis_rdfpu(dis_rdfpu), .dis_rdidx(dis_rdidx),
        .dis_pc(dis_pc),
        .ret_ena(ret_ena), .ret_ptr(ret_ptr), .ret_rdwen(ret_rdwen),
        .ret_rdfpu(ret_rdfpu), .ret_rdidx(ret_rdidx), .ret_pc(ret_pc),
        .match_rs1(match_rs1), .match_rs2(match_rs2),
        .match_rs3(match_rs3), .match_rd(match_rd),
        .empty(empty), .full(full), .err_underflow(err_underflow)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        dis_ena = 0; ret_ena = 0;
        dis_rs1en = 0; dis_rs2en = 0; dis_rs3en = 0;
        dis_rs1fpu = 0; dis_rs2fpu = 0; dis_rs3fpu = 0;
        dis_rs1idx = 0; dis_rs2idx = 0; dis_rs3idx = 0;
        dis_rdwen = 0; dis_rdfpu = 0; dis_rdidx = 0; dis_pc = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1;
        tick();
        rst = 0;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        dis_rs1en = 1; dis_rs2en = 1; dis_rs3en = 1; dis_rdwen = 1;
        #1;
        n_total++;
        if ({empty, full, dis_ready, dis_ptr, err_underflow} !== 5'b10100)
            $display("FAIL reset_flags got e/f/r/p/u=%b want 10100",
                     {empty, full, dis_ready, dis_ptr, err_underflow});
        else n_pass++;
        n_total++;
        if ({match_rs1, match_rs2, match_rs3, match_rd} !== 4'b0000)
            $display("FAIL reset_match got %b want 0000",
                     {match_rs1, match_rs2, match_rs3, match_rd});
        else n_pass++;
        idle_inputs();
    endtask

    task automatic test_fill();
        do_reset();
        dis_ena = 1; dis_rdwen = 1; dis_rdidx = 5; dis_pc = 32'h100;
        dis_rs1en = 1; dis_rs1idx = 5;
        #1;
        n_total++;
        if (match_rs1 !== 1'b0)
            $display("FAIL no_bypass got %b want 0", match_rs1);
        else n_pass++;
        tick();
        dis_rdidx = 7; dis_pc = 32'h104;
        tick();
        dis_ena = 0;
        dis_rs2en = 1; dis_rs2idx = 6;
        #1;
        n_total++;
        if ({full, dis_ready, empty} !== 3'b100)
            $display("FAIL fill_flags got f/r/e=%b want 100",
                     {full, dis_ready, empty});
        else n_pass++;
        n_total++;
        if ({match_rs1, match_rs2} !== 2'b10)
            $display("FAIL fill_match got rs1/rs2=%b want 10",
                     {match_rs1, match_rs2});
        else n_pass++;
        n_total++;
        if (ret_rdidx !== 5'd5 || ret_pc !== 32'h100 || ret_ptr !== 1'b0)
            $display("FAIL fill_head got idx=%0d pc=%h ptr=%0d want 5 100 0",
                     ret_rdidx, ret_pc, ret_ptr);
        else n_pass++;
        dis_ena = 1; dis_rdidx = 9; dis_pc = 32'h108;
        tick();
        dis_ena = 0;
        #1;
        n_total++;
        if (dis_ptr !== 1'b0 || full !== 1'b1 || ret_rdidx !== 5'd5
            || match_rd !== 1'b0)
            $display("FAIL full_ignore got ptr=%0d full=%b idx=%0d rd=%b want 0 1 5 0",
                     dis_ptr, full, ret_rdidx, match_rd);
        else n_pass++;
        idle_inputs();
    endtask

    task automatic test_full_simul();
        dis_ena = 1; ret_ena = 1; dis_rdwen = 1; dis_rdidx = 11;
        tick();
        dis_ena = 0; ret_ena = 0;
        #1;
        n_total++;
        if (full !== 1'b0 || ret_rdidx !== 5'd7 || ret_ptr !== 1'b1
            || dis_ptr !== 1'b0 || match_rd !== 1'b0)
            $display("FAIL full_simul got f=%b idx=%0d rp=%0d dp=%0d rd=%b want 0 7 1 0 0",
                     full, ret_rdidx, ret_ptr, dis_ptr, match_rd);
        else n_pass++;
        ret_ena = 1;
        tick();
        ret_ena = 0;
        n_total++;
        if (empty !== 1'b1 || err_underflow !== 1'b0)
            $display("FAIL drain got e=%b u=%b want 1 0", empty, err_underflow);
        else n_pass++;
        idle_inputs();
    endtask

    task automatic test_wrap();
        logic [0:0] exp_tag;
        do_reset();
        for (int k = 0; k < 5; k++) begin
            exp_tag = 1'(k % 2);
            n_total++;
            if (dis_ptr !== exp_tag)
                $display("FAIL wrap_tag%0d got %0d want %0d", k, dis_ptr, exp_tag);
            else n_pass++;
            dis_ena = 1; dis_rdwen = 1; dis_rdidx = 5'(k + 1);
            tick();
            dis_ena = 0;
            n_total++;
            if (empty !== 1'b0 || full !== 1'b0 || ret_ptr !== exp_tag)
                $display("FAIL wrap_alc%0d got e=%b f=%b rp=%0d want 0 0 %0d",
                         k, empty, full, ret_ptr, exp_tag);
            else n_pass++;
            ret_ena = 1;
            tick();
            ret_ena = 0;
            n_total++;
            if (empty !== 1'b1 || full !== 1'b0)
                $display("FAIL wrap_ret%0d got e=%b f=%b want 1 0", k, empty, full);
            else n_pass++;
        end
        idle_inputs();
    endtask

    task automatic test_fpu();
        do_reset();
        dis_ena = 1; dis_rdwen = 1; dis_rdfpu = 1; dis_rdidx = 3;
        tick();
        dis_rdwen = 0; dis_rdfpu = 0; dis_rdidx = 3;
        tick();
        dis_ena = 0;
        dis_rs1en = 1; dis_rs1fpu = 0; dis_rs1idx = 3;
        dis_rdwen = 1; dis_rdfpu = 0; dis_rdidx = 3;
        #1;
        n_total++;
        if (match_rs1 !== 1'b0 || match_rd !== 1'b0)
            $display("FAIL fpu_int got rs1=%b rd=%b want 0 0", match_rs1, match_rd);
        else n_pass++;
        dis_rs1fpu = 1;
        dis_rs3en = 1; dis_rs3fpu = 1; dis_rs3idx = 3;
        #1;
        n_total++;
        if (match_rs1 !== 1'b1 || match_rs3 !== 1'b1)
            $display("FAIL fpu_hit got rs1=%b rs3=%b want 1 1", match_rs1, match_rs3);
        else n_pass++;
        dis_rs3en = 0;
        #1;
        n_total++;
        if (match_rs3 !== 1'b0)
            $display("FAIL rs3_en got %b want 0", match_rs3);
        else n_pass++;
        idle_inputs();
    endtask

    task automatic test_underflow();
        do_reset();
        ret_ena = 1;
        tick();
        ret_ena = 0;
        n_total++;
        if (err_underflow !== 1'b1 || empty !== 1'b1
            || dis_ptr !== 1'b0 || ret_ptr !== 1'b0)
            $display("FAIL underflow got u=%b e=%b dp=%0d rp=%0d want 1 1 0 0",
                     err_underflow, empty, dis_ptr, ret_ptr);
        else n_pass++;
        dis_ena = 1; ret_ena = 1; dis_rdwen = 1; dis_rdidx = 4;
        tick();
        dis_ena = 0; ret_ena = 0;
        #1;
        n_total++;
        if (empty !== 1'b0 || err_underflow !== 1'b1 || match_rd !== 1'b1
            || dis_ptr !== 1'b1)
            $display("FAIL empty_simul got e=%b u=%b rd=%b dp=%0d want 0 1 1 1",
                     empty, err_underflow, match_rd, dis_ptr);
        else n_pass++;
        rst = 1;
        tick();
        rst = 0;
        #1;
        n_total++;
        if (empty !== 1'b1 || err_underflow !== 1'b0 || match_rd !== 1'b0
            || dis_ptr !== 1'b0)
            $display("FAIL mid_reset got e=%b u=%b rd=%b dp=%0d want 1 0 0 0",
                     empty, err_underflow, match_rd, dis_ptr);
        else n_pass++;
        idle_inputs();
    endtask

    initial begin
        rst = 1;
        idle_inputs();
        test_reset();
        test_fill();
        test_full_simul();
        test_wrap();
        test_fpu();
        test_underflow();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
